// File: rtl/lim_brick_pkg.sv
// Shared widths, FSM encoding and address-split helpers for the LIM brick array.
package lim_brick_pkg;

  localparam int LIM_BRICK_WORD_SIZE = 8;
  localparam int LIM_BRICK_WORD_NUM  = 16;

  typedef logic [1:0] fsm_t;
  localparam fsm_t ST_IDLE  = 2'd0;
  localparam fsm_t ST_CLEAR = 2'd1;
  localparam fsm_t ST_DRAIN = 2'd2;

  // Address layout is {brick, row}; row occupies the low row_bits.
  function automatic int unsigned addr_brick(input logic [31:0] addr, input int unsigned row_bits);
    return addr >> row_bits;
  endfunction

  function automatic int unsigned addr_row(input logic [31:0] addr, input int unsigned row_bits);
    return addr & ((32'd1 << row_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/decoder_brick.sv
// Binary row index to one-hot wordline; rows past WL_WIDTH decode to no line.
module decoder_brick #(
  parameter int WL_WIDTH = 16,
  parameter int ROW_BITS = $clog2(WL_WIDTH)
) (
  input  logic                en,
  input  logic [ROW_BITS-1:0] row,
  output logic [WL_WIDTH-1:0] wl
);

  always_comb begin
    wl = '0;
    for (int i = 0; i < WL_WIDTH; i++)
      if (en && row == ROW_BITS'(i)) wl[i] = 1'b1;
  end

endmodule

// File: rtl/sram_brick_array.sv
// NUM_BRICKS storage bricks behind one 1R/1W binary-addressed port with masked
// write-first writes, a registered read and a row-sequenced bulk-clear engine.
module sram_brick_array
  import lim_brick_pkg::*;
#(
  parameter int BL_WIDTH   = LIM_BRICK_WORD_SIZE,
  parameter int WL_WIDTH   = LIM_BRICK_WORD_NUM,
  parameter int NUM_BRICKS = 4,
  parameter int ROW_BITS   = $clog2(WL_WIDTH),
  parameter int ADDR_WIDTH = $clog2(NUM_BRICKS) + ROW_BITS,
  parameter int BRICK_BITS = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RD_READY,
  output logic                  RD_VALID,
  output logic [BL_WIDTH-1:0]   RD_DATA,
  input  logic                  WR_EN,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [BL_WIDTH-1:0]   WR_DATA,
  input  logic [BL_WIDTH-1:0]   WR_MASK,
  output logic                  WR_READY,
  input  logic                  CLR_REQ,
  input  logic [BRICK_BITS-1:0] CLR_BRICK,
  output logic                  BUSY
);

  fsm_t                  state;
  logic [ROW_BITS-1:0]   cnt;
  logic [BRICK_BITS-1:0] clr_brick;
  logic [BRICK_BITS-1:0] rd_bsel;
  logic                  busy, clearing, rd_acc, wr_acc;

  logic [BRICK_BITS-1:0] rd_brick, wr_brick, w_brick;
  logic [ROW_BITS-1:0]   rd_row, wr_row, w_row;
  logic [BL_WIDTH-1:0]   w_data, w_mask;

  logic [NUM_BRICKS-1:0][BL_WIDTH-1:0] rd_bank;

  assign busy     = (state != ST_IDLE);
  assign clearing = (state == ST_CLEAR);
  assign rd_acc   = RD_EN & ~busy;
  assign wr_acc   = WR_EN & ~busy;
  assign BUSY     = busy;
  assign RD_READY = ~busy;
  assign WR_READY = ~busy;

  assign rd_brick = BRICK_BITS'(addr_brick(32'(RD_ADDR), ROW_BITS));
  assign rd_row   = ROW_BITS'(addr_row(32'(RD_ADDR), ROW_BITS));
  assign wr_brick = BRICK_BITS'(addr_brick(32'(WR_ADDR), ROW_BITS));
  assign wr_row   = ROW_BITS'(addr_row(32'(WR_ADDR), ROW_BITS));

  // The clear engine borrows the write port; external writes are locked out while it runs.
  assign w_brick = clearing ? clr_brick : wr_brick;
  assign w_row   = clearing ? cnt       : wr_row;
  assign w_data  = clearing ? '0        : WR_DATA;
  assign w_mask  = clearing ? '1        : WR_MASK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      clr_brick <= '0;
    end else begin
      case (state)
        ST_IDLE: if (CLR_REQ) begin
          clr_brick <= CLR_BRICK;
          cnt       <= '0;
          state     <= ST_CLEAR;
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == ROW_BITS'(WL_WIDTH - 1)) state <= ST_DRAIN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      rd_bsel  <= '0;
    end else begin
      RD_VALID <= rd_acc;
      if (rd_acc) rd_bsel <= rd_brick;
    end
  end

  assign RD_DATA = rd_bank[rd_bsel];

  for (genvar b = 0; b < NUM_BRICKS; b++) begin : g_brick
    logic                wsel, rsel;
    logic [WL_WIDTH-1:0] wwl, rwl;
    logic [BL_WIDTH-1:0] mem [WL_WIDTH];
    logic [BL_WIDTH-1:0] raw, fwd, q;

    assign wsel = (clearing || wr_acc) && (w_brick == BRICK_BITS'(b));
    assign rsel = rd_acc && (rd_brick == BRICK_BITS'(b));

    decoder_brick #(.WL_WIDTH(WL_WIDTH), .ROW_BITS(ROW_BITS)) u_wdec (
      .en(wsel), .row(w_row), .wl(wwl)
    );
    decoder_brick #(.WL_WIDTH(WL_WIDTH), .ROW_BITS(ROW_BITS)) u_rdec (
      .en(rsel), .row(rd_row), .wl(rwl)
    );

    always_ff @(posedge CLK) begin
      for (int w = 0; w < WL_WIDTH; w++)
        if (wwl[w]) mem[w] <= (mem[w] & ~w_mask) | (w_data & w_mask);
    end

    always_comb begin
      raw = '0;
      for (int w = 0; w < WL_WIDTH; w++)
        if (rwl[w]) raw = raw | mem[w];
    end

    // Write-first: a read hitting the row being written sees the merged word.
    assign fwd = (|(rwl & wwl)) ? ((raw & ~w_mask) | (w_data & w_mask)) : raw;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST)       q <= '0;
      else if (rsel) q <= fwd;
    end

    assign rd_bank[b] = q;
  end

endmodule

// File: tb/tb_sram_brick_array.sv
// Scoreboarded bench for sram_brick_array: 4 bricks x 16 words x 8 bits.
module tb_sram_brick_array;

  localparam int BL = 8;
  localparam int WL = 16;
  localparam int NB = 4;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RD_EN = 1'b0, WR_EN = 1'b0, CLR_REQ = 1'b0;
  logic [AW-1:0] RD_ADDR = '0, WR_ADDR = '0;
  logic [BL-1:0] WR_DATA = '0, WR_MASK = '0;
  logic [1:0]    CLR_BRICK = '0;
  logic          RD_READY, RD_VALID, WR_READY, BUSY;
  logic [BL-1:0] RD_DATA;

  sram_brick_array #(.BL_WIDTH(BL), .WL_WIDTH(WL), .NUM_BRICKS(NB)) dut (
    .CLK(CLK), .RST(RST),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_READY(RD_READY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK), .WR_READY(WR_READY),
    .CLR_REQ(CLR_REQ), .CLR_BRICK(CLR_BRICK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  model [64];
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  int          m_left = 0;
  logic [1:0]  m_brick = '0;
  logic [3:0]  m_row = '0;

  // One clock of stimulus; the model applies the same cycle's effects and
  // queues expected read data, observed read data is queued after the edge.
  task automatic cyc(input logic re, input logic [5:0] ra, input logic we, input logic [5:0] wa,
                     input logic [7:0] wd, input logic [7:0] wm, input logic cr, input logic [1:0] cb);
    logic start;
    start = 1'b0;
    RD_EN = re; RD_ADDR = ra; WR_EN = we; WR_ADDR = wa;
    WR_DATA = wd; WR_MASK = wm; CLR_REQ = cr; CLR_BRICK = cb;
    if (m_left == 0) begin
      if (we) model[wa] = (model[wa] & ~wm) | (wd & wm);
      if (re) exp_q.push_back(model[ra]);
      if (cr) begin start = 1'b1; m_brick = cb; m_row = '0; end
    end else if (m_left > 1) begin
      model[{m_brick, m_row}] = 8'h00;
      m_row++;
    end
    @(posedge CLK);
    if (start) m_left = WL + 1;
    else if (m_left > 0) m_left--;
    #1;
    if (RD_VALID === 1'b1) obs_q.push_back(RD_DATA);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got %b want 0", RD_VALID); end
    total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL reset_rd_data got %h want 00", RD_DATA); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", BUSY); end
    total++; if (RD_READY !== 1'b1 || WR_READY !== 1'b1)
      begin bad++; $display("FAIL reset_ready got %b%b want 11", RD_READY, WR_READY); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] e, o;
    cyc(0, 0, 1, 6'd3, 8'hA5, 8'hFF, 0, 0);
    cyc(1, 6'd3, 0, 0, 0, 0, 0, 0);
    total++; if (RD_VALID !== 1'b1 || RD_DATA !== 8'hA5)
      begin bad++; $display("FAIL basic_read got v=%b d=%h want v=1 d=a5", RD_VALID, RD_DATA); end
    idle();
    total++; if (RD_VALID !== 1'b0 || RD_DATA !== 8'hA5)
      begin bad++; $display("FAIL basic_hold got v=%b d=%h want v=0 d=a5", RD_VALID, RD_DATA); end
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mask();
    logic [7:0] e, o;
    cyc(0, 0, 1, 6'd3, 8'h0F, 8'h0F, 0, 0);
    cyc(1, 6'd3, 0, 0, 0, 0, 0, 0);
    total++; if (RD_DATA !== 8'hAF) begin bad++; $display("FAIL mask_merge got %h want af", RD_DATA); end
    cyc(0, 0, 1, 6'd3, 8'h55, 8'h00, 0, 0);
    cyc(1, 6'd3, 0, 0, 0, 0, 0, 0);
    idle();
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL mask_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mask_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_forward();
    logic [7:0] e, o;
    cyc(0, 0, 1, 6'd5, 8'h11, 8'hFF, 0, 0);
    cyc(1, 6'd5, 1, 6'd5, 8'h22, 8'hFF, 0, 0);
    total++; if (RD_DATA !== 8'h22) begin bad++; $display("FAIL fwd_same got %h want 22", RD_DATA); end
    cyc(1, 6'd3, 1, 6'd6, 8'h77, 8'hFF, 0, 0);
    total++; if (RD_DATA !== 8'hAF) begin bad++; $display("FAIL fwd_diff got %h want af", RD_DATA); end
    cyc(1, 6'd6, 1, 6'd6, 8'hF0, 8'h3C, 0, 0);
    cyc(1, 6'd5, 0, 0, 0, 0, 0, 0);
    idle();
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL fwd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL fwd_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 6'(48 + i), 8'($urandom), 8'hFF, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 6'(55 - i), 0, 0, 0, 0, 0, 0);
    idle();
    total++; if (obs_q.size() != 8 || exp_q.size() != 8)
      begin bad++; $display("FAIL b2b_count got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL b2b_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear();
    logic [7:0] e, o;
    int n, ready_bad;
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 6'(16 + i), 8'(i + 1), 8'hFF, 0, 0);
    cyc(0, 0, 1, 6'd36, 8'h5A, 8'hFF, 0, 0);
    cyc(1, 6'd36, 0, 0, 0, 0, 1, 2'd1);
    n = 0; ready_bad = 0;
    for (int i = 0; i < 40 && BUSY === 1'b1; i++) begin
      n++;
      if (RD_READY !== 1'b0 || WR_READY !== 1'b0) ready_bad++;
      cyc(1, 6'd3, 1, 6'd3, 8'hFF, 8'hFF, i == 5, 2'd2);
    end
    total++; if (n != WL + 1) begin bad++; $display("FAIL clear_busy_len got %0d want %0d", n, WL + 1); end
    total++; if (ready_bad != 0) begin bad++; $display("FAIL clear_ready got %0d want 0", ready_bad); end
    for (int i = 0; i < WL; i++) cyc(1, 6'(16 + i), 0, 0, 0, 0, 0, 0);
    cyc(1, 6'd36, 0, 0, 0, 0, 0, 0);
    cyc(1, 6'd3, 0, 0, 0, 0, 0, 0);
    idle();
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL clear_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL clear_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] e, o;
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 6'(32 + i), 8'h80 | 8'(i), 8'hFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'd2);
    for (int i = 0; i < 40 && !(m_left > 1 && m_row == 4'd7); i++) idle();
    total++; if (!(m_left > 1 && m_row == 4'd7))
      begin bad++; $display("FAIL rstclr_reach got row=%0d want 7", m_row); end
    RST = 1'b1;
    #1;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rstclr_busy got %b want 0", BUSY); end
    total++; if (RD_READY !== 1'b1) begin bad++; $display("FAIL rstclr_ready got %b want 1", RD_READY); end
    m_left = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < WL; i++) cyc(1, 6'(32 + i), 0, 0, 0, 0, 0, 0);
    idle();
    total++; if (obs_q.size() != WL || exp_q.size() != WL)
      begin bad++; $display("FAIL rstclr_count got %0d want %0d", obs_q.size(), WL); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rstclr_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    test_reset();
    test_basic();
    test_mask();
    test_forward();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
